// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//
// Fetch-side controller feeding the IF/ID register. It owns the fetch PC,
// issues requests to a variable-latency instruction memory and applies the
// ID-stage stall and the EX-stage branch redirect. A one-entry skid buffer
// catches a beat that lands while decode is stalled, so no beat is lost.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-low reset
//   stall_req      ID asks IF/ID to hold (load-use hazard)
//   branch_taken   redirect fetch this cycle and flush IF/ID
//   branch_target  redirect address, low two bits ignored
//   mem_req        instruction memory request
//   mem_addr       request address
//   mem_ready      memory returns mem_rdata this cycle
//   mem_rdata      fetched instruction
//   pc_ID          PC of the instruction in IF/ID
//   instr_ID       instruction in IF/ID
//   valid_ID       IF/ID holds a real instruction
//   busy           a fetch is outstanding (FETCH or DROP)
//
// Memory handshake: a beat completes on a rising edge where mem_req=1 and
// mem_ready=1 (mem_ready may rise in the same cycle mem_req rises). While
// mem_req=1 and mem_ready=0, mem_addr is held stable. Once issued, a request
// is never withdrawn except by reset; a redirect lets the old beat finish
// (DROP) and throws its data away. mem_rdata is only looked at when a beat
// completes.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] drop_addr;   // address of the abandoned beat still in flight
  logic [31:0] skid_pc;     // skid contents are meaningful only in HOLD
  logic [31:0] skid_instr;
  logic [31:0] target_aligned;

  assign target_aligned = {branch_target[31:2], 2'b00};

  // Outputs decode straight from the state register, so reset drops
  // mem_req without waiting for a clock.
  assign mem_req  = (state == FETCH) || (state == DROP);
  assign busy     = mem_req;
  assign mem_addr = (state == DROP) ? drop_addr : fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drop_addr  <= RESET_PC;
      skid_pc    <= 32'h0;
      skid_instr <= NOP_INSTR;
      pc_ID      <= 32'h0;
      instr_ID   <= NOP_INSTR;
      valid_ID   <= 1'b0;
    end else if (branch_taken) begin
      // Redirect beats stall and any completing beat. pc_ID is left alone;
      // the bubble is marked by valid_ID=0 and a NOP.
      fetch_pc <= target_aligned;
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= FETCH;
          end else begin
            // The old beat is still owed to us; keep its address on the bus.
            state     <= DROP;
            drop_addr <= fetch_pc;
          end
        end
        DROP:    state <= mem_ready ? FETCH : DROP;
        default: state <= FETCH;  // IDLE and HOLD (skid discarded)
      endcase
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (mem_ready) begin
            if (stall_req) begin
              skid_pc    <= fetch_pc;
              skid_instr <= mem_rdata;
              state      <= HOLD;
            end else begin
              pc_ID    <= fetch_pc;
              instr_ID <= mem_rdata;
              valid_ID <= 1'b1;
            end
            fetch_pc <= fetch_pc + 32'd4;  // wraps mod 2^32
          end
        end
        HOLD: begin
          if (!stall_req) begin
            pc_ID    <= skid_pc;
            instr_ID <= skid_instr;
            valid_ID <= 1'b1;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (mem_ready) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a behavioural
// model made of a few variables and a skid queue.

module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        stall_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] pc_ID;
  logic [31:0] instr_ID;
  logic        valid_ID;
  logic        busy;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .pc_ID         (pc_ID),
    .instr_ID      (instr_ID),
    .valid_ID      (valid_ID),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // started: one cycle has passed since reset. A request is outstanding
  // whenever we have started and nothing sits in the skid. m_discard marks
  // an old beat that must be absorbed before the redirected fetch begins.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_discard;
  logic [31:0] m_drop;
  logic [63:0] skid_q[$];
  logic [31:0] m_if_pc;
  logic [31:0] m_if_instr;
  bit          m_if_valid;

  task automatic m_reset();
    m_started = 0; m_pc = 32'h0; m_discard = 0; m_drop = 32'h0;
    skid_q.delete();
    m_if_pc = 32'h0; m_if_instr = NOP; m_if_valid = 0;
  endtask

  function automatic bit m_req();
    return m_started && (skid_q.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_discard ? m_drop : m_pc;
  endfunction

  task automatic m_step(input bit s, input bit b, input logic [31:0] t,
                        input bit r, input logic [31:0] d);
    bit req;
    logic [63:0] e;
    req = m_req();
    if (!m_started) begin
      m_started = 1;
      if (b) begin m_pc = t & ~32'd3; m_if_instr = NOP; m_if_valid = 0; end
    end else if (b) begin
      if (req && !r && !m_discard) begin
        m_discard = 1; m_drop = m_pc;
      end else if (m_discard && r) begin
        m_discard = 0;
      end
      m_pc = t & ~32'd3;
      m_if_instr = NOP; m_if_valid = 0;
      skid_q.delete();
    end else if (m_discard) begin
      if (r) m_discard = 0;
    end else if (skid_q.size() != 0) begin
      if (!s) begin
        e = skid_q.pop_front();
        m_if_pc = e[63:32]; m_if_instr = e[31:0]; m_if_valid = 1;
      end
    end else if (r) begin
      if (s) skid_q.push_back({m_pc, d});
      else begin m_if_pc = m_pc; m_if_instr = d; m_if_valid = 1; end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("mem_req", {31'h0, mem_req}, {31'h0, m_req()});
    chk("busy", {31'h0, busy}, {31'h0, m_req()});
    if (m_req()) chk("mem_addr", mem_addr, m_addr());
    chk("pc_ID", pc_ID, m_if_pc);
    chk("instr_ID", instr_ID, m_if_instr);
    chk("valid_ID", {31'h0, valid_ID}, {31'h0, m_if_valid});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: check outputs, drive one cycle of inputs,
  // advance the model across the coming rising edge.
  task automatic go_d(input bit s, input bit b, input logic [31:0] t,
                      input bit r, input logic [31:0] d);
    compare_all();
    stall_req = s; branch_taken = b; branch_target = t;
    mem_ready = r; mem_rdata = d;
    m_step(s, b, t, r, d);
    @(negedge clk);
  endtask

  task automatic go(input bit s, input bit b, input logic [31:0] t, input bit r);
    go_d(s, b, t, r, m_addr() + 32'd100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_pc_ID", pc_ID, 32'h0);
    chk("rst_instr_ID", instr_ID, NOP);
    chk("rst_valid_ID", {31'h0, valid_ID}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;

    // zero-wait memory, one instruction per cycle after one IDLE cycle
    go(0, 0, 0, 0);
    chk("t1_req_first", {31'h0, mem_req}, 32'h1);
    chk("t1_addr_first", mem_addr, 32'h0);
    go(0, 0, 0, 1);
    chk("t1_pc0", pc_ID, 32'h0); chk("t1_in0", instr_ID, 32'd100);
    chk("t1_v0", {31'h0, valid_ID}, 32'h1);
    go(0, 0, 0, 1);
    chk("t1_pc4", pc_ID, 32'h4); chk("t1_in4", instr_ID, 32'd104);
    go(0, 0, 0, 1);
    chk("t1_pc8", pc_ID, 32'h8); chk("t1_in8", instr_ID, 32'd108);

    // three wait cycles per beat
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr_held", mem_addr, 32'hC);
      chk("t2_busy", {31'h0, busy}, 32'h1);
      go(0, 0, 0, 0);
      chk("t2_if_hold", pc_ID, 32'h8);
    end
    go(0, 0, 0, 1);
    chk("t2_pcC", pc_ID, 32'hC); chk("t2_inC", instr_ID, 32'd112);

    // stall while the 0x10 beat completes: skid then release
    go(1, 0, 0, 1);
    chk("t3_if_kept", pc_ID, 32'hC);
    for (int i = 0; i < 3; i++) begin
      chk("t3_no_req", {31'h0, mem_req}, 32'h0);
      go(1, 0, 0, 1);
      chk("t3_if_kept2", pc_ID, 32'hC);
    end
    go(0, 0, 0, 0);
    chk("t3_pc10", pc_ID, 32'h10); chk("t3_in10", instr_ID, 32'd116);
    chk("t3_next_addr", mem_addr, 32'h14);

    // redirect while the 0x14 beat is waiting
    go(0, 0, 0, 0);
    go(0, 1, 32'h40, 0);
    chk("t4_valid0", {31'h0, valid_ID}, 32'h0);
    chk("t4_nop", instr_ID, NOP);
    chk("t4_drop_addr", mem_addr, 32'h14);
    go(0, 0, 0, 1);
    chk("t4_discarded", {31'h0, valid_ID}, 32'h0);
    chk("t4_new_addr", mem_addr, 32'h40);
    go(0, 0, 0, 1);
    chk("t4_pc40", pc_ID, 32'h40); chk("t4_in40", instr_ID, 32'h40 + 32'd100);

    // branch and stall together with a completing beat
    go(1, 1, 32'h83, 1);
    chk("t5_flush", {31'h0, valid_ID}, 32'h0);
    chk("t5_addr", mem_addr, 32'h80);
    chk("t5_req", {31'h0, mem_req}, 32'h1);
    go(0, 0, 0, 1);
    chk("t5_pc80", pc_ID, 32'h80);

    // wrap at the top of the address space
    go(0, 1, 32'hFFFF_FFFC, 1);
    go(0, 0, 0, 1);
    chk("t6_pc_top", pc_ID, 32'hFFFF_FFFC);
    chk("t6_wrap_addr", mem_addr, 32'h0);

    // reset mid-DROP, asserted between clock edges
    go(0, 1, 32'h200, 0);
    chk("t7_in_drop", {31'h0, busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t7_req", {31'h0, mem_req}, 32'h0);
    chk("t7_busy", {31'h0, busy}, 32'h0);
    chk("t7_valid", {31'h0, valid_ID}, 32'h0);
    chk("t7_pc", pc_ID, 32'h0);
    chk("t7_instr", instr_ID, NOP);
    m_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    go(0, 0, 0, 0);
    chk("t7_restart_addr", mem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      go_d($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom);
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-side pipeline controller that sequences instruction fetch into the IF/ID register.
- Owns the fetch PC, issues requests to a variable-latency instruction memory over a req/ready handshake, and applies ID-stage stall and EX-stage branch redirect.
- Holds a one-entry skid buffer so a fetch that completes during a stall is never lost.
- Sits between the branch/hazard logic and the instruction memory; drives the IF/ID outputs consumed by decode.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction injected on flush/bubble (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
stall_req  input  1  ID requests IF/ID hold (load-use hazard)
branch_taken  input  1  redirect fetch this cycle; flushes IF/ID
branch_target  input  32  redirect address, valid with branch_taken
mem_req  output  1  instruction memory request
mem_addr  output  32  request address; stable while mem_req=1 and mem_ready=0
mem_ready  input  1  memory returns mem_rdata this cycle (same-cycle allowed)
mem_rdata  input  32  fetched instruction
pc_ID  output  32  PC of instruction in IF/ID
instr_ID  output  32  instruction in IF/ID
valid_ID  output  1  IF/ID holds a real instruction
busy  output  1  fetch outstanding (state FETCH or DROP)

Behaviour:
- Reset state (async, reset=0):
  - state=IDLE, fetch_pc=RESET_PC, pc_ID=0, instr_ID=NOP_INSTR, valid_ID=0, mem_req=0, skid empty.
- States:
  - IDLE: mem_req=0. Next cycle -> FETCH. Only entered from reset.
  - FETCH: mem_req=1, mem_addr=fetch_pc.
    - mem_ready=0: stay.
    - mem_ready=1, stall_req=0: IF/ID <= {fetch_pc, mem_rdata, valid=1}; fetch_pc += 4; stay FETCH. Throughput is one instruction/cycle with a zero-wait memory.
    - mem_ready=1, stall_req=1: skid <= {fetch_pc, mem_rdata}; fetch_pc += 4; -> HOLD. IF/ID unchanged.
  - HOLD: mem_req=0. When stall_req=0: IF/ID <= skid (valid=1), skid cleared, -> FETCH.
  - DROP: mem_req=1, mem_addr=old address, kept stable per protocol. On mem_ready=1: discard data, -> FETCH at the redirected fetch_pc.
- Branch (branch_taken=1) has priority over stall and over any completing fetch:
  - Always: fetch_pc <= branch_target; IF/ID <= {pc_ID unchanged, NOP_INSTR, valid=0}; skid cleared.
  - From FETCH with mem_ready=0: -> DROP; the new target is fetched after the old beat returns.
  - From FETCH with mem_ready=1: that data is discarded; -> FETCH at the new target next cycle.
  - From HOLD or DROP: -> FETCH (from DROP, only once mem_ready=1; otherwise stay DROP).
- stall_req while IF/ID valid and no fetch completing: IF/ID holds its value, with no change to fetch_pc.
- stall_req and branch_taken together: the branch wins (flush); the stall is ignored that cycle.
- Arithmetic: fetch_pc+4 is mod 2^32; 32'hFFFF_FFFC wraps to 0. branch_target bits [1:0] are forced to 0.
- mem_rdata is ignored whenever mem_ready=0 or the state is not FETCH/DROP.
- Reset asserted mid-fetch: immediate return to the reset state, mem_req=0 asynchronously. The memory must tolerate abandoned requests.
- busy=1 exactly in FETCH and DROP.

Test Plan:
- Reset release, memory ready every cycle with rdata=addr+100: IDLE 1 cycle, then pc_ID=0,4,8,... on consecutive cycles, with instr_ID=100,104,108 and valid_ID=1.
- Memory wait of 3 cycles per beat: mem_addr held at 0x0 for 3 cycles; IF/ID updates once per 4 cycles; busy=1 throughout.
- stall_req=1 for 4 cycles while a beat at 0x8 completes: IF/ID stays at 0x4; mem_req=0 during HOLD; after release, pc_ID=0x8 with the correct data and no beat lost or duplicated.
- branch_taken with target 0x40 while a beat to 0xC is waiting (ready 2 cycles later): valid_ID=0 and instr_ID=0x13 next cycle; the 0xC beat is discarded; the next request is 0x40 and pc_ID=0x40 arrives valid.
- branch_taken and stall_req in the same cycle with ready=1: flush occurs, no skid capture, and the next mem_addr=branch_target.
- Reset pulsed mid-DROP, plus fetch_pc at 0xFFFF_FFFC: outputs return to reset values asynchronously; in the wrap case the next fetch address is 0x0.
